memory_stage: RTL and testbench
===============================

# memory_stage

Pipeline MEM stage of the 64-bit LEGv8 core, directly downstream of the execute stage. It registers the execute results (ALU result, store data, zero flag, branch target) with their control bits, and resolves conditional branches for fetch. It runs loads and stores against the data memory through a req/ack handshake, stalling the upstream pipeline while an access is outstanding. It then delivers a registered MEM/WB bundle to writeback.

## Interface
- `N`, 64, datapath width.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `PCBranch_E`, `aluResult_E`, `writeData_E` in N: execute results.
- `zero_E` in 1: ALU zero flag.
- `valid_E`, `MemRead_E`, `MemWrite_E`, `Branch_E`, `RegWrite_E`, `MemtoReg_E` in 1: control bits for the instruction.
- `rd_E` in 5: destination register.
- `stall_M` out 1: freeze the upstream stages and hold the `*_E` inputs.
- `PCSrc_M` out 1: branch taken.
- `PCBranch_M` out N: branch target to fetch.
- `dm_req`, `dm_we` out 1: data memory request / write enable.
- `dm_addr`, `dm_wdata` out N: data memory address / store data.
- `dm_ack` in 1: data memory completion.
- `dm_rdata` in N: load data, valid when `dm_ack`=1.
- `valid_W`, `RegWrite_W`, `MemtoReg_W` out 1: writeback control.
- `rd_W` out 5: writeback destination register.
- `aluResult_W`, `readData_W` out N: writeback data.
- `misalign_M` out 1: misaligned access flag (see Configuration).

## Operation
- **M register.** Holds the `*_M` copies of every `*_E` input. It loads on each rising edge where `stall_M`=0 and holds otherwise.
- **Memory op.** `memop_M = valid_M & (MemRead_M | MemWrite_M)`.
- **FSM states: IDLE, REQ.**
  - The next state is evaluated only on edges where the M register loads: REQ if the incoming instruction is a memory op (and passes the alignment check when enabled), else IDLE.
  - In REQ with `dm_ack`=0, the state stays REQ.
- **Memory port in REQ.**
  - `dm_req`=1, `dm_we`=`MemWrite_M`, `dm_addr`=`aluResult_M`, `dm_wdata`=`writeData_M`.
  - All four are stable until the edge where `dm_ack`=1 is sampled.
  - In IDLE: `dm_req`=0 and `dm_we`=0.
- **Stall.** `stall_M` = (state==REQ) & ~`dm_ack`, combinational. An ack in the first REQ cycle is legal and gives zero stall cycles.
- **Back-to-back ops.** On the ack edge the next instruction loads. If it is also a memory op, the FSM stays in REQ with the new address. `dm_req` therefore stays high across consecutive accesses.
- **MEM/WB register.** Updates every edge.
  - If `stall_M`=1: it loads a bubble (`valid_W`=0, `RegWrite_W`=0).
  - Otherwise: it loads the M contents, with `readData_W` = `dm_rdata` when the M instruction is a load, else 0.
- **Branch.** `PCSrc_M` = `valid_M` & `Branch_M` & `zero_M`; `PCBranch_M` = `PCBranch_M` register. Both are combinational from the M register. Flushing the younger stages is the hazard unit's job.
- **Invalid instruction.** `valid_E`=0 is a bubble. It never issues a request and never asserts `PCSrc_M`.

## Timing
- **Reset values.** All M and W registers are 0, state IDLE. Therefore `dm_req`, `dm_we`, `stall_M`, `PCSrc_M`, `valid_W`, `RegWrite_W`, `MemtoReg_W`, `misalign_M` = 0, and all buses = 0.
- **Reset mid-access.** Asserting `reset` mid-access drops `dm_req` immediately (asynchronously). A late `dm_ack` after reset release is ignored while IDLE.
- **Latency, non-memory.** `*_E` sampled at edge t appears on `*_W` after edge t+1.
- **Latency, memory op.** `*_W` appears after the edge on which `dm_ack` is sampled: edge t+1+k for k wait cycles.
- **`dm_ack` outside REQ** is ignored.

## Configuration
- `MISALIGN_CHECK_EN` defined:
  - A memory op with `aluResult_E[2:0]`≠0 does not enter REQ.
  - `misalign_M`=1 for the cycle that instruction is in M.
  - It reaches W as a bubble (`valid_W`=0, `RegWrite_W`=0).
- `MISALIGN_CHECK_EN` undefined: no check; `misalign_M` is tied 0; every address is issued as-is.

## Test plan
- **Reset:** assert `reset`=0 mid-REQ with `dm_req`=1 → `dm_req` drops to 0 without a clock; all outputs 0; after release, an ack pulse is ignored.
- **ALU op:** `aluResult_E`=0x40, `RegWrite_E`=1, `rd_E`=5 → `aluResult_W`=0x40, `rd_W`=5, `valid_W`=1 one edge later; `stall_M` never asserts.
- **Load with 3 wait cycles:** load with `aluResult_E`=0x100, ack after 3 cycles with `dm_rdata`=0xDEADBEEF → `dm_addr`=0x100 held 4 cycles; `stall_M`=1 for 3 cycles; W gets 3 bubbles, then `readData_W`=0xDEADBEEF.
- **Back-to-back store then load:** store to 0x8 with data 0x55, ack same cycle, followed by a load from 0x10 → `dm_req` high continuously; `dm_we` 1 then 0; `dm_addr` 0x8 then 0x10; zero stall cycles.
- **Branch:** `Branch_E`=1 with `zero_E`=1 and `PCBranch_E`=0x200 → `PCSrc_M`=1 and `PCBranch_M`=0x200 for one cycle; with `zero_E`=0, `PCSrc_M`=0.
- **Misaligned load at 0x104:** with `MISALIGN_CHECK_EN` → `dm_req` stays 0, `misalign_M`=1, `valid_W`=0. Without the macro → a normal request to 0x104.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: LEGv8 MEM stage - M register, branch resolve, req/ack data memory FSM, MEM/WB register.
// Optional MISALIGN_CHECK_EN: suppresses memory ops whose address is not 8-byte aligned.
module memory_stage #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] PCBranch_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic         zero_E,
    input  logic         valid_E,
    input  logic         MemRead_E,
    input  logic         MemWrite_E,
    input  logic         Branch_E,
    input  logic         RegWrite_E,
    input  logic         MemtoReg_E,
    input  logic [4:0]   rd_E,
    output logic         stall_M,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_M,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic         dm_ack,
    input  logic [N-1:0] dm_rdata,
    output logic         valid_W,
    output logic         RegWrite_W,
    output logic         MemtoReg_W,
    output logic [4:0]   rd_W,
    output logic [N-1:0] aluResult_W,
    output logic [N-1:0] readData_W,
    output logic         misalign_M
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t state_q, state_d;
    logic valid_q, mem_read_q, mem_write_q, branch_q, reg_write_q, mem_to_reg_q, zero_q;
    logic [4:0] rd_q;
    logic [N-1:0] alu_q, wdata_q, pcb_q;
    logic misalign_e, misalign_m;
`ifdef MISALIGN_CHECK_EN
    assign misalign_e = valid_E & (MemRead_E | MemWrite_E) & (aluResult_E[2:0] != 3'd0);
    assign misalign_m = valid_q & (mem_read_q | mem_write_q) & (alu_q[2:0] != 3'd0);
`else
    assign misalign_e = 1'b0;
    assign misalign_m = 1'b0;
`endif
    assign stall_M    = (state_q == REQ) & ~dm_ack;
    assign state_d    = stall_M ? state_q
                      : (valid_E & (MemRead_E | MemWrite_E) & ~misalign_e) ? REQ : IDLE;
    assign dm_req     = (state_q == REQ);
    assign dm_we      = dm_req & mem_write_q;
    assign dm_addr    = alu_q;
    assign dm_wdata   = wdata_q;
    assign PCSrc_M    = valid_q & branch_q & zero_q;
    assign PCBranch_M = pcb_q;
    assign misalign_M = misalign_m;
    // W takes a bubble while stalled or when the M instruction was dropped as misaligned
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            zero_q       <= 1'b0;
            rd_q         <= '0;
            alu_q        <= '0;
            wdata_q      <= '0;
            pcb_q        <= '0;
            valid_W      <= 1'b0;
            RegWrite_W   <= 1'b0;
            MemtoReg_W   <= 1'b0;
            rd_W         <= '0;
            aluResult_W  <= '0;
            readData_W   <= '0;
        end else begin
            state_q <= state_d;
            if (!stall_M) begin
                valid_q      <= valid_E;
                mem_read_q   <= MemRead_E;
                mem_write_q  <= MemWrite_E;
                branch_q     <= Branch_E;
                reg_write_q  <= RegWrite_E;
                mem_to_reg_q <= MemtoReg_E;
                zero_q       <= zero_E;
                rd_q         <= rd_E;
                alu_q        <= aluResult_E;
                wdata_q      <= writeData_E;
                pcb_q        <= PCBranch_E;
            end
            if (stall_M || misalign_m) begin
                valid_W     <= 1'b0;
                RegWrite_W  <= 1'b0;
                MemtoReg_W  <= 1'b0;
                rd_W        <= '0;
                aluResult_W <= '0;
                readData_W  <= '0;
            end else begin
                valid_W     <= valid_q;
                RegWrite_W  <= reg_write_q;
                MemtoReg_W  <= mem_to_reg_q;
                rd_W        <= rd_q;
                aluResult_W <= alu_q;
                readData_W  <= (valid_q & mem_read_q) ? dm_rdata : '0;
            end
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized + directed scoreboard bench for memory_stage.
module tb_memory_stage;
    localparam int N = 64;
    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] PCBranch_E, aluResult_E, writeData_E;
    logic zero_E, valid_E, MemRead_E, MemWrite_E, Branch_E, RegWrite_E, MemtoReg_E;
    logic [4:0] rd_E;
    logic stall_M, PCSrc_M, dm_req, dm_we, valid_W, RegWrite_W, MemtoReg_W, misalign_M;
    logic [N-1:0] PCBranch_M, dm_addr, dm_wdata, aluResult_W, readData_W;
    logic [4:0] rd_W;
    logic dm_ack = 1'b0;
    logic [N-1:0] dm_rdata = '0;

    memory_stage #(.N(N)) dut (
        .clk(clk), .reset(reset), .PCBranch_E(PCBranch_E), .aluResult_E(aluResult_E),
        .writeData_E(writeData_E), .zero_E(zero_E), .valid_E(valid_E), .MemRead_E(MemRead_E),
        .MemWrite_E(MemWrite_E), .Branch_E(Branch_E), .RegWrite_E(RegWrite_E),
        .MemtoReg_E(MemtoReg_E), .rd_E(rd_E), .stall_M(stall_M), .PCSrc_M(PCSrc_M),
        .PCBranch_M(PCBranch_M), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .valid_W(valid_W),
        .RegWrite_W(RegWrite_W), .MemtoReg_W(MemtoReg_W), .rd_W(rd_W),
        .aluResult_W(aluResult_W), .readData_W(readData_W), .misalign_M(misalign_M)
    );

    typedef struct {
        logic v, mr, mw, br, rw, mtr, z;
        logic [4:0] rd;
        logic [63:0] alu, wd, pcb;
    } instr_t;
    typedef struct {
        logic rw, mtr;
        logic [4:0] rd;
        logic [63:0] alu, rdata;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    logic [63:0] model_mem[logic [63:0]];
    logic [63:0] resp_mem[logic [63:0]];
    int checks = 0, failures = 0;
    int fixed_delay = -1;
    bit spur_en = 0, ack_pulse = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] init_val(input logic [63:0] a);
        return a ^ 64'hA5A5_0000_C3C3_1234;
    endfunction

    function automatic logic [63:0] model_rd(input logic [63:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    function automatic logic [63:0] resp_rd(input logic [63:0] a);
        return resp_mem.exists(a) ? resp_mem[a] : init_val(a);
    endfunction

    task automatic drive(input instr_t in);
        valid_E = in.v; MemRead_E = in.mr; MemWrite_E = in.mw; Branch_E = in.br;
        RegWrite_E = in.rw; MemtoReg_E = in.mtr; zero_E = in.z; rd_E = in.rd;
        aluResult_E = in.alu; writeData_E = in.wd; PCBranch_E = in.pcb;
    endtask

    function automatic instr_t mk(input logic v, mr, mw, br, rw, z, input logic [4:0] rd,
                                  input logic [63:0] alu, wd, pcb);
        instr_t r;
        r.v = v; r.mr = mr; r.mw = mw; r.br = br; r.rw = rw; r.mtr = mr; r.z = z;
        r.rd = rd; r.alu = alu; r.wd = wd; r.pcb = pcb;
        return r;
    endfunction

    // Data memory: random wait states, latches the request on its first cycle and checks it holds
    int wait_cnt = 0;
    bit busy = 0;
    logic [63:0] lat_addr, lat_wdata;
    logic lat_we;
    always @(negedge clk) begin
        dm_ack = 1'b0;
        dm_rdata = {$urandom, $urandom};
        if (!reset) busy = 0;
        else if (dm_req) begin
            if (!busy) begin
                busy = 1;
                wait_cnt = fixed_delay >= 0 ? fixed_delay : int'($urandom_range(0, 3));
                lat_addr = dm_addr; lat_we = dm_we; lat_wdata = dm_wdata;
            end else begin
                chk("dm_addr_hold", dm_addr, lat_addr);
                chk("dm_we_hold", dm_we, lat_we);
                chk("dm_wdata_hold", dm_wdata, lat_wdata);
            end
            if (wait_cnt == 0) begin
                dm_ack = 1'b1;
                busy = 0;
                if (dm_we) resp_mem[dm_addr] = dm_wdata;
                else dm_rdata = resp_rd(dm_addr);
            end else wait_cnt--;
        end else dm_ack = ack_pulse | (spur_en && $urandom_range(0, 3) == 0);
    end

    always @(posedge clk) begin
        #1;
        if (reset && valid_W) begin
            if (q.size() == 0) chk("w_unexpected_valid", valid_W, 1'b0);
            else begin
                mon_e = q.pop_front();
                chk("w_regwrite", RegWrite_W, mon_e.rw);
                chk("w_memtoreg", MemtoReg_W, mon_e.mtr);
                chk("w_rd", rd_W, mon_e.rd);
                chk("w_alu", aluResult_W, mon_e.alu);
                chk("w_rdata", readData_W, mon_e.rdata);
            end
        end
    end

    task automatic issue(input instr_t in, output int stalls);
        bit ok = 0, mis, memop;
        exp_t e;
        instr_t z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        memop = in.v && (in.mr || in.mw);
`ifdef MISALIGN_CHECK_EN
        mis = memop && in.alu[2:0] != 3'd0;
`else
        mis = 0;
`endif
        drive(in);
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #2;
            if (!stall_M) begin ok = 1; break; end
            stalls++;
        end
        chk("issue_accept", ok, 1'b1);
        if (ok && in.v && !mis) begin
            e.rw = in.rw; e.mtr = in.mtr; e.rd = in.rd; e.alu = in.alu;
            e.rdata = in.mr ? model_rd(in.alu) : 64'd0;
            if (in.mw) model_mem[in.alu] = in.wd;
            q.push_back(e);
        end
        @(posedge clk); #1;
        drive(z);
        if (ok) begin
            chk("pcsrc", PCSrc_M, in.v & in.br & in.z);
            chk("pcbranch", PCBranch_M, in.pcb);
            chk("misalign", misalign_M, mis);
            chk("dm_req", dm_req, memop && !mis);
            if (memop && !mis) begin
                chk("dm_addr", dm_addr, in.alu);
                chk("dm_we", dm_we, in.mw);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (q.size() != 0 || dm_req); i++) begin
            @(posedge clk); #2;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic chk_zero(input string name);
        chk(name, {dm_req, dm_we, stall_M, PCSrc_M, valid_W, RegWrite_W, MemtoReg_W, misalign_M, rd_W}, 0);
        chk({name, "_bus"}, PCBranch_M | dm_addr | dm_wdata | aluResult_W | readData_W, 0);
    endtask

    function automatic instr_t rand_instr();
        instr_t r;
        int k = $urandom_range(0, 3);
        logic [63:0] a = {$urandom, $urandom};
        if (k == 1 || k == 2) begin
            a = 64'({$urandom_range(0, 31), 3'b000});
            if ($urandom_range(0, 9) == 0) a = a + 64'($urandom_range(1, 7));
        end
        r = mk($urandom_range(0, 9) != 0, k == 1, k == 2, k == 3, 1'($urandom), 1'($urandom),
               5'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom});
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st, cnt;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #3;
        chk_zero("reset_outputs");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // ALU op: one-edge latency, no stall
        issue(mk(1, 0, 0, 0, 1, 0, 5'd5, 64'h40, 0, 0), st);
        chk("alu_stall", st, 0);
        @(posedge clk); #1;
        chk("alu_valid_w", valid_W, 1'b1);
        chk("alu_result_w", aluResult_W, 64'h40);
        chk("alu_rd_w", rd_W, 5);
        drain();

        // Load with 3 wait cycles
        model_mem[64'h100] = 64'hDEADBEEF;
        resp_mem[64'h100] = 64'hDEADBEEF;
        fixed_delay = 3;
        issue(mk(1, 1, 0, 0, 1, 0, 5'd7, 64'h100, 0, 0), st);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("ld_req_held", dm_req, 1'b1);
            chk("ld_addr_held", dm_addr, 64'h100);
            chk("ld_w_bubble", valid_W, 1'b0);
            cnt += int'(stall_M);
        end
        chk("ld_stall_cycles", cnt, 3);
        @(posedge clk); #1;
        chk("ld_valid_w", valid_W, 1'b1);
        chk("ld_rdata_w", readData_W, 64'hDEADBEEF);
        drain();

        // Back-to-back store then load, ack in first REQ cycle
        fixed_delay = 0;
        issue(mk(1, 0, 1, 0, 0, 0, 0, 64'h8, 64'h55, 0), st);
        issue(mk(1, 1, 0, 0, 1, 0, 5'd3, 64'h10, 0, 0), st);
        chk("b2b_stall", st, 0);
        issue(mk(1, 1, 0, 0, 1, 0, 5'd4, 64'h8, 0, 0), st);
        drain();

        // Branch taken / not taken
        issue(mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 64'h200), st);
        issue(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 64'h300), st);
        @(posedge clk); #1;
        chk("branch_one_cycle", PCSrc_M, 1'b0);

        // Misaligned load
        issue(mk(1, 1, 0, 0, 1, 0, 5'd9, 64'h104, 0, 0), st);
        drain();

        // Randomized traffic with random wait states and spurious acks while idle
        fixed_delay = -1;
        spur_en = 1;
        for (int i = 0; i < 300; i++) issue(rand_instr(), st);
        drain();
        spur_en = 0;

        // Reset during an outstanding load, then a stray ack
        fixed_delay = 6;
        issue(mk(1, 1, 0, 0, 1, 0, 5'd2, 64'h20, 0, 0), st);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("reset_mid_access");
        q.delete();
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        ack_pulse = 1;
        @(negedge clk); #1;
        chk("late_ack_stall", stall_M, 1'b0);
        ack_pulse = 0;
        @(posedge clk); #1;
        chk("late_ack_req", dm_req, 1'b0);
        chk("late_ack_w", valid_W, 1'b0);

        // Pipeline still works after reset
        fixed_delay = -1;
        for (int i = 0; i < 20; i++) issue(rand_instr(), st);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
